// File: rtl/counter_pkg.sv
// Shared types and constants for the counter tick controller.
package counter_pkg;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_TICK_HZ         = 1;
  localparam int DEF_WIDTH           = 6;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

  // Clock cycles per auto-count tick at the default board rates.
  localparam int DIV = DEF_CLK_HZ / DEF_TICK_HZ;

  // Prescaler divide ratio for an arbitrary clock / tick pair (must be >= 2).
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed for a counter spanning 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_tick_ctrl_debouncer.sv
// Pushbutton debouncer: accepts a new level only after it has been seen for
// DEBOUNCE_CYCLES consecutive samples, and emits a one-cycle press pulse one
// cycle after the debounced level rises.
module debouncer
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;

  // Stability counter, accepted level, and registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (din == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= din;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/counter_tick_ctrl.sv
// Counter source for the six-digit binary display: prescaled auto-count,
// run/pause and single-step buttons, up/down switch, update strobe.
module counter_tick_ctrl
  import counter_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int TICK_HZ         = DEF_TICK_HZ,
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             dir_sw,
  output logic [WIDTH-1:0] q,
  output logic             q_upd,
  output logic             running
);

  localparam int                 TICK_DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int                 PRESC_W    = cnt_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  // Raw inputs bundled as {dir, step, run} so they share one synchronizer.
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  logic [1:0] w_press;
  logic [1:0] w_level_unused;
  logic       w_run_press;
  logic       w_step_press;
  logic       w_dir_down;

  run_state_t         r_state;
  run_state_t         w_state_next;
  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;
  logic               w_count_event;
  logic [WIDTH-1:0]   r_q;
  logic               r_q_upd;

  assign w_raw = {dir_sw, step_btn, run_btn};

  // Two-flop synchronizer for every asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per button: index 0 is run/pause, index 1 is single-step.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .din   (r_sync2[gi]),
        .level (w_level_unused[gi]),
        .press (w_press[gi])
      );
    end
  endgenerate

  assign w_run_press  = w_press[0];
  assign w_step_press = w_press[1];
  assign w_dir_down   = r_sync2[2];

  // Tick fires in the cycle the prescaler sits at its last value while running.
  assign w_tick = (r_state == RUNNING) && (r_presc == PRESC_LAST);

  // Run state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PAUSED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and count-event decode; a run press never blocks the event.
  always_comb begin
    w_state_next  = r_state;
    w_count_event = 1'b0;
    case (r_state)
      PAUSED: begin
        if (w_step_press) begin
          w_count_event = 1'b1;
        end
        if (w_run_press) begin
          w_state_next = RUNNING;
        end
      end
      RUNNING: begin
        if (w_tick) begin
          w_count_event = 1'b1;
        end
        if (w_run_press) begin
          w_state_next = PAUSED;
        end
      end
      default: begin
        w_state_next = PAUSED;
      end
    endcase
  end

  // Prescaler: free-runs 0..DIV-1 while running, parked at zero when paused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_state == RUNNING) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
    end else begin
      r_presc <= '0;
    end
  end

  // Count register with wrap-around in both directions and its update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      r_q_upd <= 1'b0;
    end else begin
      r_q_upd <= w_count_event;
      if (w_count_event) begin
        r_q <= w_dir_down ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));
      end
    end
  end

  assign q       = r_q;
  assign q_upd   = r_q_upd;
  assign running = (r_state == RUNNING);

endmodule

// File: tb/tb_counter_tick_ctrl.sv
// Self-checking bench for counter_tick_ctrl with a small clock/debounce setup.
module tb_counter_tick_ctrl;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int WIDTH   = 6;
  localparam int DEB     = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int MODV    = 1 << WIDTH;
  localparam int LAT_UPD = 2 + DEB + 1 + 1;  // raw rise cycle -> q_upd cycle

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             run_btn = 1'b0;
  logic             step_btn = 1'b0;
  logic             dir_sw = 1'b0;
  logic [WIDTH-1:0] q;
  logic             q_upd;
  logic             running;

  always #5 clk = ~clk;

  counter_tick_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .run_btn(run_btn), .step_btn(step_btn),
    .dir_sw(dir_sw), .q(q), .q_upd(q_upd), .running(running)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw input history: the value a raw input had two edges ago is what the
  // design may act on now. Debounce: the level flips once the last DEB
  // samples all disagree with it. A press is seen one cycle after the level rose.
  int m_q, m_upd, m_run, m_rc;
  int rq [3][2];         // {run, step, dir} raw values from the last two edges
  int dh [2][DEB];       // last DEB debounce samples per button
  int lv [2];            // debounced level
  int lvp[2];            // debounced level one edge earlier
  int pr [2];            // press visible in the current cycle

  task automatic model_edge();
    int s[3];
    int raw[3];
    int tick, ev, np, all_diff;
    if (reset) begin
      m_q = 0; m_upd = 0; m_run = 0; m_rc = 0;
      for (int k = 0; k < 3; k++) begin rq[k][0] = 0; rq[k][1] = 0; end
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEB; i++) dh[b][i] = 0;
        lv[b] = 0; lvp[b] = 0; pr[b] = 0;
      end
    end else begin
      raw[0] = run_btn; raw[1] = step_btn; raw[2] = dir_sw;
      for (int k = 0; k < 3; k++) begin
        s[k] = rq[k][0]; rq[k][0] = rq[k][1]; rq[k][1] = raw[k];
      end
      tick = (m_run != 0) && ((m_rc % DIV) == DIV - 1);
      ev   = tick || (m_run == 0 && pr[1] != 0);
      m_upd = ev;
      if (ev) m_q = (s[2] != 0) ? (m_q + MODV - 1) % MODV : (m_q + 1) % MODV;
      if (pr[0] != 0) begin m_run = 1 - m_run; m_rc = 0; end
      else if (m_run != 0) m_rc++;
      for (int b = 0; b < 2; b++) begin
        np = (lv[b] != 0 && lvp[b] == 0);
        lvp[b] = lv[b];
        for (int i = 0; i < DEB - 1; i++) dh[b][i] = dh[b][i+1];
        dh[b][DEB-1] = s[b];
        all_diff = 1;
        for (int i = 0; i < DEB; i++) if (dh[b][i] == lv[b]) all_diff = 0;
        if (all_diff) lv[b] = 1 - lv[b];
        pr[b] = np;
      end
    end
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked.
  task automatic cycle_once();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_val("q", int'(q), m_q);
    check_val("q_upd", int'(q_upd), m_upd);
    check_val("running", int'(running), m_run);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle_once();
  endtask

  // Hold a button for 'hold' cycles then release for 'gap'; report the
  // q_upd latency counted from the cycle the raw level rose (-1 if none).
  task automatic pulse(input int which, input int hold, input int gap, output int lat);
    lat = -1;
    if (which == 0) run_btn = 1'b1; else step_btn = 1'b1;
    for (int i = 0; i < hold + gap; i++) begin
      if (i == hold) begin run_btn = 1'b0; step_btn = 1'b0; end
      cycle_once();
      if (q_upd && lat < 0) lat = i + 1;
    end
    run_btn = 1'b0; step_btn = 1'b0;
  endtask

  initial begin
    int lat, t_enter, n_upd, q0, first_upd;
    int hold_r, hold_s, hold_d;

    // Reset and idle
    reset = 1'b1; run_cycles(2); reset = 1'b0;
    run_cycles(50);
    check_val("idle_q", int'(q), 0);
    check_val("idle_running", int'(running), 0);

    // Single steps upward, exact press latency
    dir_sw = 1'b0;
    pulse(1, 10, 12, lat);
    check_val("step_latency", lat, LAT_UPD);
    check_val("step1_q", int'(q), 1);
    pulse(1, 10, 12, lat);
    pulse(1, 10, 12, lat);
    check_val("three_steps_q", int'(q), 3);

    // Short glitch is rejected
    pulse(1, 2, 12, lat);
    check_val("glitch_no_upd", lat, -1);
    check_val("glitch_q", int'(q), 3);

    // Run, ticks every DIV cycles, then a run press aligned with a tick
    q0 = int'(q); t_enter = -1; n_upd = 0; first_upd = -1;
    run_btn = 1'b1;
    for (int i = 0; i < 5 * DIV + 12; i++) begin
      if (i == 6) run_btn = 1'b0;
      if (i == 5 * DIV) run_btn = 1'b1;
      if (i == 5 * DIV + 6) run_btn = 1'b0;
      cycle_once();
      if (running && t_enter < 0) t_enter = i;
      if (q_upd && i < 5 * DIV) begin
        n_upd++;
        if (first_upd < 0) first_upd = i;
      end
      if (i == 5 * DIV + 7) begin
        check_val("tick_stop_upd", int'(q_upd), 1);
        check_val("tick_stop_running", int'(running), 0);
        check_val("tick_stop_q", int'(q), (q0 + 5) % MODV);
      end
    end
    check_val("run_enter", t_enter, 2 + DEB + 1);
    check_val("first_tick_offset", first_upd - t_enter, DIV);
    check_val("run_ticks", n_upd, 4);

    // Reset mid-RUNNING, then prescaler restarts from zero
    pulse(0, 6, 20, lat);
    check_val("rerun_running", int'(running), 1);
    reset = 1'b1; cycle_once(); reset = 1'b0;
    check_val("rst_q", int'(q), 0);
    check_val("rst_running", int'(running), 0);
    t_enter = -1; first_upd = -1;
    run_btn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 6) run_btn = 1'b0;
      cycle_once();
      if (running && t_enter < 0) t_enter = i;
      if (q_upd && first_upd < 0) first_upd = i;
    end
    check_val("restart_tick_offset", first_upd - t_enter, DIV);
    pulse(0, 6, 12, lat);
    check_val("paused_again", int'(running), 0);

    // Wrap-around in both directions
    reset = 1'b1; cycle_once(); reset = 1'b0;
    dir_sw = 1'b1; run_cycles(4);
    pulse(1, 6, 12, lat);
    check_val("down_from_0", int'(q), MODV - 1);
    dir_sw = 1'b0; run_cycles(4);
    pulse(1, 6, 12, lat);
    check_val("up_from_63", int'(q), 0);
    dir_sw = 1'b1; run_cycles(4);
    pulse(1, 6, 12, lat);
    check_val("down_to_63", int'(q), MODV - 1);

    // Randomized stretches of button/switch activity against the model
    hold_r = 0; hold_s = 0; hold_d = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold_r == 0) begin run_btn = 1'($urandom_range(0, 1)); hold_r = $urandom_range(1, 12); end
      if (hold_s == 0) begin step_btn = 1'($urandom_range(0, 1)); hold_s = $urandom_range(1, 10); end
      if (hold_d == 0) begin dir_sw = 1'($urandom_range(0, 1)); hold_d = $urandom_range(1, 40); end
      reset = ($urandom_range(0, 299) == 0);
      hold_r--; hold_s--; hold_d--;
      cycle_once();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_tick_ctrl.md
Name: counter_tick_ctrl

Overview:
- Upstream stage of the six-digit binary counter display.
- Generates the counter value `q` that the display stage renders bit-per-digit as "1"/"0" on seg0..seg5.
- Contains a clock prescaler for an auto-count tick, debounced run/pause and single-step pushbuttons, a direction switch, and the count register itself.
- Emits a one-cycle update strobe each time `q` changes.

Parameters:
- CLK_HZ, 50_000_000: board clock frequency in Hz.
- TICK_HZ, 1: auto-count rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be at least 2.
- WIDTH, 6: counter width; one display digit per bit.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz).

Ports:
- clk  in  1  board clock.
- reset  in  1  synchronous, active-high reset.
- run_btn  in  1  raw run/pause pushbutton, active-high, asynchronous to clk.
- step_btn  in  1  raw single-step pushbutton, active-high, asynchronous to clk.
- dir_sw  in  1  raw slide switch: 0 = count up, 1 = count down.
- q  out  WIDTH  counter value to the display stage.
- q_upd  out  1  one-cycle pulse, high in the same cycle `q` shows its new value.
- running  out  1  high while in RUNNING state.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is sampled only on the rising edge of clk.
  - After any edge with reset=1: q=0, q_upd=0, running=0, state=PAUSED, prescaler=0, synchronizers=0, debounced levels=0, debounce counters=0.
  - Reset asserted mid-count or mid-debounce aborts everything; a press in progress is discarded.
- Input conditioning:
  - Every raw input passes through a 2-flop synchronizer.
  - dir_sw is used after synchronization, without debounce.
- Debounce, per button:
  - Track the synchronized level. Whenever the level differs from the debounced level, a counter increments; any sample equal to the debounced level clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the level still differs, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle press pulse. Falling edges produce nothing.
  - Latency from a clean raw edge to the press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles (fixed; the bench checks it exactly).
- State machine, states PAUSED and RUNNING:
  - PAUSED -> RUNNING on a run press.
  - RUNNING -> PAUSED on a run press.
  - No other transitions.
- Prescaler, range 0..DIV-1:
  - In RUNNING it increments every cycle. At DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - In PAUSED it is held at 0. Entering RUNNING therefore gives the first tick exactly DIV cycles after the transition edge.
- Count events:
  - A tick in RUNNING, or a step press in PAUSED, causes one count event. Step presses in RUNNING are ignored.
  - Up: q+1 modulo 2^WIDTH (63 -> 0). Down: q-1 modulo 2^WIDTH (0 -> 63).
  - dir_sw is sampled (synchronized value) in the cycle of the event.
  - `q` registers the new value on the edge following the event cycle. q_upd is high for exactly that cycle.
  - No event means q holds and q_upd=0.
- Simultaneous events:
  - Run press in the same cycle as a tick: the count event is applied and the state toggles to PAUSED on the same edge.
  - Run press and step press in the same PAUSED cycle: the state goes to RUNNING and the step is also applied, giving one count event.
  - Both buttons held continuously produce no further pulses.

Decomposition:
- Package counter_pkg:
  - `typedef enum logic {PAUSED, RUNNING} run_state_t`
  - localparam DIV, derived from CLK_HZ/TICK_HZ
  - default WIDTH constant
- Sub-module debouncer:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, reset, din (synchronized), level, press.
  - Instantiated twice, once for run and once for step.

Test Plan (CLK_HZ=10, TICK_HZ=1 so DIV=10; DEBOUNCE_CYCLES=4):
- Reset, then idle 50 cycles -> q=0, running=0, q_upd never high.
- Step pulse held 10 cycles in PAUSED with dir_sw=0 -> press exactly 7 cycles after the raw rise; q=1 one cycle later with a single q_upd; 3 steps give q=3.
- Glitch 2 cycles wide on step_btn -> no press, q unchanged.
- Run press, then observe 35 cycles -> running=1; ticks at +10/+20/+30 cycles after the transition; q increments 3 times, each with one q_upd.
- Start at q=63, dir_sw=0, one step -> q=0. Then dir_sw=1, one step -> q=63.
- Run press aligned with the tick cycle -> q increments once and running=0 on the same edge. Then reset asserted for 1 cycle mid-RUNNING -> next edge gives q=0, running=0, and the prescaler restarts at 0.
